// File: rtl/alu8_seq_pkg.sv
// Shared types and constants for the 8-bit nibble-sequenced ALU front end.
package alu8_seq_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 8;

    localparam logic MODE_LOGIC = 1'b1;
    localparam logic MODE_ARITH = 1'b0;

    localparam logic [3:0] FN_ADD = 4'b1001;
    localparam logic [3:0] FN_XOR = 4'b0110;
endpackage

// File: rtl/ula_74181.sv
// 4-bit 74181-style ALU slice: active-high data, active-low c_in, active-high c_out.
// a_eq_b reports nibble operand equality.
module ula_74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out,
    output logic       a_eq_b
);
    logic [3:0] op1, op2, lf;
    logic [4:0] sum;

    // Arithmetic codes reduce to op1 + op2 + carry; "minus 1" is adding 4'hF.
    always_comb begin
        op1 = a;
        op2 = 4'h0;
        case (s)
            4'b0000: begin op1 = a;        op2 = 4'h0;     end
            4'b0001: begin op1 = a | b;    op2 = 4'h0;     end
            4'b0010: begin op1 = a | ~b;   op2 = 4'h0;     end
            4'b0011: begin op1 = 4'h0;     op2 = 4'hF;     end
            4'b0100: begin op1 = a;        op2 = a & ~b;   end
            4'b0101: begin op1 = a | b;    op2 = a & ~b;   end
            4'b0110: begin op1 = a;        op2 = ~b;       end
            4'b0111: begin op1 = a & ~b;   op2 = 4'hF;     end
            4'b1000: begin op1 = a;        op2 = a & b;    end
            4'b1001: begin op1 = a;        op2 = b;        end
            4'b1010: begin op1 = a | ~b;   op2 = a & b;    end
            4'b1011: begin op1 = a & b;    op2 = 4'hF;     end
            4'b1100: begin op1 = a;        op2 = a;        end
            4'b1101: begin op1 = a | b;    op2 = a;        end
            4'b1110: begin op1 = a | ~b;   op2 = a;        end
            default: begin op1 = a;        op2 = 4'hF;     end
        endcase
    end

    always_comb begin
        lf = 4'h0;
        case (s)
            4'b0000: lf = ~a;
            4'b0001: lf = ~(a | b);
            4'b0010: lf = ~a & b;
            4'b0011: lf = 4'h0;
            4'b0100: lf = ~(a & b);
            4'b0101: lf = ~b;
            4'b0110: lf = a ^ b;
            4'b0111: lf = a & ~b;
            4'b1000: lf = ~a | b;
            4'b1001: lf = ~(a ^ b);
            4'b1010: lf = b;
            4'b1011: lf = a & b;
            4'b1100: lf = 4'h1;
            4'b1101: lf = a | ~b;
            4'b1110: lf = a | b;
            default: lf = a;
        endcase
    end

    assign sum    = {1'b0, op1} + {1'b0, op2} + {4'h0, ~c_in};
    assign f      = m ? lf : sum[3:0];
    assign c_out  = m ? 1'b0 : sum[4];
    assign a_eq_b = (a == b);
endmodule

// File: rtl/alu8_nibble_sequencer.sv
// Issues one 8-bit op as two chained passes through a shared 4-bit ula_74181 slice.
// Optional ALU8_SEQ_FLAGS_EN adds rsp_a_eq_b and rsp_zero outputs.
module alu8_nibble_sequencer
    import alu8_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] cmd_a,
    input  logic [WORD_W-1:0] cmd_b,
    input  logic [3:0]        cmd_s,
    input  logic              cmd_m,
    input  logic              cmd_cin_n,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_f,
    output logic              rsp_cout
`ifdef ALU8_SEQ_FLAGS_EN
    ,
    output logic              rsp_a_eq_b,
    output logic              rsp_zero
`endif
);
    state_t state, state_nxt;

    logic [WORD_W-1:0]   a_q, b_q;
    logic [3:0]          s_q;
    logic                m_q, cin_n_q, carry_lo;
    logic [NIBBLE_W-1:0] sl_a, sl_b, sl_f;
    logic                sl_cin, sl_cout, sl_eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = LO;
            LO:      state_nxt = HI;
            HI:      state_nxt = DONE;
            default: if (rsp_ready) state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

    // High pass gets the inverted low carry-out to match the active-low c_in.
    always_comb begin
        sl_a   = a_q[NIBBLE_W-1:0];
        sl_b   = b_q[NIBBLE_W-1:0];
        sl_cin = cin_n_q;
        if (state == HI) begin
            sl_a   = a_q[WORD_W-1:NIBBLE_W];
            sl_b   = b_q[WORD_W-1:NIBBLE_W];
            sl_cin = ~carry_lo;
        end
    end

    ula_74181 u_slice (
        .a      (sl_a),
        .b      (sl_b),
        .s      (s_q),
        .m      (m_q),
        .c_in   (sl_cin),
        .f      (sl_f),
        .c_out  (sl_cout),
        .a_eq_b (sl_eq)
    );

`ifdef ALU8_SEQ_FLAGS_EN
    logic eq_lo, eq_hi;
    assign rsp_a_eq_b = eq_lo & eq_hi;
    // Gated so the flag reads 0 at reset even though rsp_f resets to zero.
    assign rsp_zero   = rsp_valid & (rsp_f == '0);
`else
    logic unused_sl_eq;
    assign unused_sl_eq = sl_eq;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            cin_n_q  <= 1'b0;
            carry_lo <= 1'b0;
            rsp_f    <= '0;
            rsp_cout <= 1'b0;
`ifdef ALU8_SEQ_FLAGS_EN
            eq_lo    <= 1'b0;
            eq_hi    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    a_q     <= cmd_a;
                    b_q     <= cmd_b;
                    s_q     <= cmd_s;
                    m_q     <= cmd_m;
                    cin_n_q <= cmd_cin_n;
                end
                LO: begin
                    rsp_f[NIBBLE_W-1:0] <= sl_f;
                    carry_lo            <= sl_cout;
`ifdef ALU8_SEQ_FLAGS_EN
                    eq_lo               <= sl_eq;
`endif
                end
                HI: begin
                    rsp_f[WORD_W-1:NIBBLE_W] <= sl_f;
                    rsp_cout                 <= sl_cout;
`ifdef ALU8_SEQ_FLAGS_EN
                    eq_hi                    <= sl_eq;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu8_nibble_sequencer.sv
// Self-checking bench for alu8_nibble_sequencer: directed cases, backpressure,
// mid-operation reset and randomized commands against a word-level model.
module tb_alu8_nibble_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] cmd_s;
    logic       cmd_m, cmd_cin_n;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_f;
    logic       rsp_cout;
`ifdef ALU8_SEQ_FLAGS_EN
    logic       rsp_a_eq_b, rsp_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu8_nibble_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_s     (cmd_s),
        .cmd_m     (cmd_m),
        .cmd_cin_n (cmd_cin_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_cout  (rsp_cout)
`ifdef ALU8_SEQ_FLAGS_EN
        ,
        .rsp_a_eq_b(rsp_a_eq_b),
        .rsp_zero  (rsp_zero)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: logic ops are bitwise on 8 bits (constant-1 code
    // yields 1 per nibble); additive arithmetic codes are plain 9-bit sums.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, b, input logic [3:0] s,
                                           input logic m, cin_n);
        logic [8:0] c;
        c = {8'h0, ~cin_n};
        if (m) begin
            case (s)
                4'b0000: return {1'b0, ~a};
                4'b0001: return {1'b0, ~(a | b)};
                4'b0010: return {1'b0, ~a & b};
                4'b0011: return 9'h000;
                4'b0100: return {1'b0, ~(a & b)};
                4'b0101: return {1'b0, ~b};
                4'b0110: return {1'b0, a ^ b};
                4'b0111: return {1'b0, a & ~b};
                4'b1000: return {1'b0, ~a | b};
                4'b1001: return {1'b0, ~(a ^ b)};
                4'b1010: return {1'b0, b};
                4'b1011: return {1'b0, a & b};
                4'b1100: return 9'h011;
                4'b1101: return {1'b0, a | ~b};
                4'b1110: return {1'b0, a | b};
                default: return {1'b0, a};
            endcase
        end
        case (s)
            4'b1001: return {1'b0, a} + {1'b0, b} + c;
            4'b1100: return {1'b0, a} + {1'b0, a} + c;
            default: return {1'b0, a} + c;
        endcase
    endfunction

    // Called #1 after a rising edge with the block idle and rsp_ready high.
    task automatic run_cmd(input logic [7:0] a, b, input logic [3:0] s, input logic m, cin_n,
                           input logic [7:0] exp_f, input logic exp_cout);
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_s = s; cmd_m = m; cmd_cin_n = cin_n;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_s = 4'($urandom);
        chk("lo_ready", cmd_ready, 0);
        chk("lo_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("hi_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_f", rsp_f, exp_f);
        chk("rsp_cout", rsp_cout, exp_cout);
`ifdef ALU8_SEQ_FLAGS_EN
        chk("rsp_a_eq_b", rsp_a_eq_b, a == b);
        chk("rsp_zero", rsp_zero, exp_f == 8'h00);
`endif
        @(posedge clk); #1;
        chk("back_idle", cmd_ready, 1);
        chk("valid_drop", rsp_valid, 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rs;
        logic       rm, rc;
        logic [8:0] e;

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h0; cmd_b = 8'h0; cmd_s = 4'h0;
        cmd_m = 1'b0; cmd_cin_n = 1'b1; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_f", rsp_f, 8'h00);
        chk("rst_cout", rsp_cout, 0);
`ifdef ALU8_SEQ_FLAGS_EN
        chk("rst_eq", rsp_a_eq_b, 0);
        chk("rst_zero", rsp_zero, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(8'h3C, 8'h58, 4'b1001, 1'b0, 1'b1, 8'h94, 1'b0);
        run_cmd(8'h3C, 8'h58, 4'b1001, 1'b0, 1'b0, 8'h95, 1'b0);
        run_cmd(8'hF0, 8'h10, 4'b1001, 1'b0, 1'b1, 8'h00, 1'b1);
        run_cmd(8'hA5, 8'h0F, 4'b0110, 1'b1, 1'b1, 8'hAA, 1'b0);
        run_cmd(8'h77, 8'h77, 4'b0110, 1'b1, 1'b1, 8'h00, 1'b0);
        run_cmd(8'h5A, 8'hC3, 4'b1100, 1'b1, 1'b0, 8'h11, 1'b0);
        run_cmd(8'hFF, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1);
        run_cmd(8'h81, 8'h00, 4'b1100, 1'b0, 1'b1, 8'h02, 1'b1);

        // Backpressure: result must hold and no new command may be taken.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_a = 8'hA5; cmd_b = 8'h0F; cmd_s = 4'b0110; cmd_m = 1'b1;
        @(posedge clk); #1;
        cmd_a = 8'h12; cmd_b = 8'h34; cmd_s = 4'b1001; cmd_m = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_valid", rsp_valid, 1);
        chk("bp_f", rsp_f, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cmd_a = 8'($urandom); cmd_b = 8'($urandom);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_f", rsp_f, 8'hAA);
            chk("bp_hold_cout", rsp_cout, 0);
            chk("bp_no_accept", cmd_ready, 0);
        end
        cmd_a = 8'h3C; cmd_b = 8'h58; cmd_s = 4'b1001; cmd_m = 1'b0; cmd_cin_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", cmd_ready, 1);
        chk("bp_release_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("bp_new_accept", cmd_ready, 0);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_new_valid", rsp_valid, 1);
        chk("bp_new_f", rsp_f, 8'h94);
        @(posedge clk); #1;

        // Reset while the high pass is in flight.
        cmd_valid = 1'b1; cmd_a = 8'hA5; cmd_b = 8'h0F; cmd_s = 4'b1001; cmd_m = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_f", rsp_f, 8'h00);
        chk("mid_rst_cout", rsp_cout, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_hold_valid", rsp_valid, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", rsp_valid, 0);
            chk("post_rst_ready", cmd_ready, 1);
        end
        run_cmd(8'h3C, 8'h58, 4'b1001, 1'b0, 1'b0, 8'h95, 1'b0);

        // Random commands: all logic codes plus the additive arithmetic codes.
        for (int n = 0; n < 60; n++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rm = 1'($urandom); rc = 1'($urandom);
            if (n % 10 == 0) rb = ra;
            if (rm) rs = 4'($urandom);
            else case ($urandom_range(2, 0))
                0:       rs = 4'b0000;
                1:       rs = 4'b1001;
                default: rs = 4'b1100;
            endcase
            e = ref_alu(ra, rb, rs, rm, rc);
            run_cmd(ra, rb, rs, rm, rc, e[7:0], e[8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
